// File: rtl/run_sequencer_pkg.sv
// Shared state encoding, output bundle and defaults for the run sequencer.
package Definitions;

   localparam int RUN_SEQ_RESET_CYCLES = 2;

   typedef enum logic [2:0] {
      IDLE,
      RST,
      START,
      RUN,
      NEXT,
      FIN,
      ERR
   } run_state_t;

   typedef struct packed {
      logic core_reset;
      logic core_start;
      logic busy;
      logic done;
      logic timeout;
   } seq_outs_t;

   // Moore decode; the top registers this from the next state so outputs
   // always match the state register exactly.
   function automatic seq_outs_t decode_outputs(input run_state_t s);
      seq_outs_t o;
      o.core_reset = (s != START) && (s != RUN);
      o.core_start = (s == START);
      o.busy       = (s != IDLE) && (s != FIN) && (s != ERR);
      o.done       = (s == FIN);
      o.timeout    = (s == ERR);
      return o;
   endfunction

endpackage

// File: rtl/run_sequencer_cycle_counter.sv
// Saturating per-run cycle counter with synchronous clear and limit compare.
module run_cycle_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] limit,
   output logic [CNT_WIDTH-1:0] count,
   output logic                 at_limit
);

   logic [CNT_WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (en && (count_reg != '1)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign count    = count_reg;
   assign at_limit = (count_reg == limit);

endmodule

// File: rtl/run_sequencer.sv
// Host-driven core run sequencer: resets, starts and times N back-to-back core runs.
// Optional per-run watchdog is compiled in with RUN_SEQ_WATCHDOG_EN.
module run_sequencer
   import Definitions::*;
#(
   parameter int RUN_WIDTH    = 4,
   parameter int CNT_WIDTH    = 16,
   parameter int RESET_CYCLES = RUN_SEQ_RESET_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 go,
   input  logic [RUN_WIDTH-1:0] num_runs,
   input  logic [CNT_WIDTH-1:0] timeout_cycles,
   input  logic                 core_done,
   output logic                 core_reset,
   output logic                 core_start,
   output logic                 busy,
   output logic                 done,
   output logic                 timeout,
   output logic [RUN_WIDTH-1:0] run_idx,
   output logic [CNT_WIDTH-1:0] cycle_count
);

   localparam logic [3:0] RST_LAST = 4'(RESET_CYCLES - 1);

   run_state_t           state_reg, state_next;
   seq_outs_t            outs_reg;
   logic [3:0]           rst_cnt_reg;
   logic [RUN_WIDTH-1:0] num_runs_reg;
   logic [RUN_WIDTH-1:0] run_idx_reg;
   logic [RUN_WIDTH-1:0] run_idx_inc;
   logic [CNT_WIDTH-1:0] limit_reg;
   logic                 cnt_clr, cnt_en, at_limit, wd_hit;

`ifdef RUN_SEQ_WATCHDOG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         limit_reg <= '0;
      end else if ((state_reg == IDLE) && go) begin
         limit_reg <= timeout_cycles;
      end
   end

   // A zero limit disables the watchdog.
   assign wd_hit  = (limit_reg != '0) && at_limit;
   assign timeout = outs_reg.timeout;
`else
   logic unused_watchdog;

   assign limit_reg       = '0;
   assign wd_hit          = 1'b0;
   assign timeout         = 1'b0;
   assign unused_watchdog = ^{timeout_cycles, at_limit, outs_reg.timeout};
`endif

   assign run_idx_inc = run_idx_reg + 1'b1;

   // core_done is checked first so completion wins over a same-cycle watchdog match.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (go) state_next = (num_runs == '0) ? FIN : RST;
         RST:      if (rst_cnt_reg == RST_LAST) state_next = START;
         START:    state_next = RUN;
         RUN: begin
            if (core_done) begin
               state_next = NEXT;
            end else if (wd_hit) begin
               state_next = ERR;
            end
         end
         NEXT:     state_next = (run_idx_inc == num_runs_reg) ? FIN : RST;
         FIN, ERR: if (!go) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         outs_reg     <= decode_outputs(IDLE);
         rst_cnt_reg  <= '0;
         num_runs_reg <= '0;
         run_idx_reg  <= '0;
      end else begin
         state_reg <= state_next;
         outs_reg  <= decode_outputs(state_next);
         if ((state_reg == IDLE) && go) begin
            num_runs_reg <= num_runs;
            run_idx_reg  <= '0;
         end
         if (state_reg == NEXT) begin
            run_idx_reg <= run_idx_inc;
         end
         rst_cnt_reg <= (state_reg == RST) ? rst_cnt_reg + 1'b1 : 4'd0;
      end
   end

   assign cnt_clr = (state_reg == START);
   assign cnt_en  = (state_reg == RUN) && !core_done && !wd_hit;

   run_cycle_counter #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_cycle_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .limit    (limit_reg),
      .count    (cycle_count),
      .at_limit (at_limit)
   );

   assign core_reset = outs_reg.core_reset;
   assign core_start = outs_reg.core_start;
   assign busy       = outs_reg.busy;
   assign done       = outs_reg.done;
   assign run_idx    = run_idx_reg;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer with a reactive core model.
module tb_run_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        go;
   logic [3:0]  num_runs;
   logic [15:0] timeout_cycles;
   logic        core_done;
   logic        core_reset, core_start, busy, done, timeout;
   logic [3:0]  run_idx;
   logic [15:0] cycle_count;

   int n_checks = 0;
   int n_errors = 0;

   // core model controls
   int done_at   = 0;
   int done_runs = 0;

   always #5 clk = ~clk;

   run_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .go             (go),
      .num_runs       (num_runs),
      .timeout_cycles (timeout_cycles),
      .core_done      (core_done),
      .core_reset     (core_reset),
      .core_start     (core_start),
      .busy           (busy),
      .done           (done),
      .timeout        (timeout),
      .run_idx        (run_idx),
      .cycle_count    (cycle_count)
   );

   // Core raises done while running once its cycle count reaches done_at.
   always @(negedge clk) begin
      core_done = !core_reset && !core_start && busy &&
                  (int'(cycle_count) == done_at) && (int'(run_idx) < done_runs);
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic start_seq(input logic [3:0] nr, input logic [15:0] tmo);
      @(negedge clk);
      num_runs       = nr;
      timeout_cycles = tmo;
      go             = 1'b1;
   endtask

   task automatic wait_end(input int budget, inout int starts);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (core_start) starts++;
         if (done || timeout) break;
      end
      check_val("end_reached", 32'(done | timeout), 1);
   endtask

   task automatic back_to_idle();
      @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   initial begin
      int starts;
      int lat;
      reset_n        = 1'b0;
      go             = 1'b0;
      num_runs       = '0;
      timeout_cycles = '0;
      core_done      = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("rst_core_reset", 32'(core_reset), 1);
      check_val("rst_core_start", 32'(core_start), 0);
      check_val("rst_busy", 32'(busy), 0);
      check_val("rst_done", 32'(done), 0);
      check_val("rst_timeout", 32'(timeout), 0);
      check_val("rst_run_idx", 32'(run_idx), 0);
      check_val("rst_cycle_count", 32'(cycle_count), 0);
      $display("txn reset: core_reset=%0d run_idx=%0d", core_reset, run_idx);

      // two runs, done at count 10
      done_at = 10; done_runs = 16;
      start_seq(4'd2, 16'd0);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (core_start) begin lat = i; break; end
      end
      check_val("start_latency", 32'(lat), 3);
      starts = 1;
      wait_end(100, starts);
      check_val("two_runs_starts", 32'(starts), 2);
      check_val("two_runs_done", 32'(done), 1);
      check_val("two_runs_run_idx", 32'(run_idx), 2);
      check_val("two_runs_cycles", 32'(cycle_count), 10);
      check_val("two_runs_core_reset", 32'(core_reset), 1);
      check_val("two_runs_busy", 32'(busy), 0);
      $display("txn two_runs: starts=%0d run_idx=%0d cycle_count=%0d", starts, run_idx, cycle_count);

      // go held high through FIN: no rerun
      starts = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (core_start) starts++;
      end
      check_val("fin_hold_starts", 32'(starts), 0);
      check_val("fin_hold_done", 32'(done), 1);
      go = 1'b0;
      @(negedge clk);
      check_val("fin_exit_done", 32'(done), 0);
      check_val("fin_exit_busy", 32'(busy), 0);
      check_val("fin_exit_run_idx", 32'(run_idx), 2);
      $display("txn fin_hold: done=%0d busy=%0d", done, busy);

      // zero runs goes straight to FIN
      start_seq(4'd0, 16'd0);
      @(negedge clk);
      check_val("zero_runs_done", 32'(done), 1);
      check_val("zero_runs_core_reset", 32'(core_reset), 1);
      check_val("zero_runs_core_start", 32'(core_start), 0);
      check_val("zero_runs_run_idx", 32'(run_idx), 0);
      $display("txn zero_runs: done=%0d run_idx=%0d", done, run_idx);
      back_to_idle();

      // done coincides with limit: completion wins
      done_at = 5; done_runs = 16;
      start_seq(4'd1, 16'd5);
      starts = 0;
      wait_end(60, starts);
      check_val("tie_done", 32'(done), 1);
      check_val("tie_timeout", 32'(timeout), 0);
      check_val("tie_cycles", 32'(cycle_count), 5);
      check_val("tie_run_idx", 32'(run_idx), 1);
      $display("txn tie: done=%0d timeout=%0d cycle_count=%0d", done, timeout, cycle_count);
      back_to_idle();

      // core never finishes, limit 5
      done_runs = 0;
      start_seq(4'd1, 16'd5);
`ifdef RUN_SEQ_WATCHDOG_EN
      starts = 0;
      wait_end(60, starts);
      check_val("wd_timeout", 32'(timeout), 1);
      check_val("wd_cycles", 32'(cycle_count), 5);
      check_val("wd_core_reset", 32'(core_reset), 1);
      check_val("wd_busy", 32'(busy), 0);
      check_val("wd_done", 32'(done), 0);
      $display("txn watchdog: timeout=%0d cycle_count=%0d", timeout, cycle_count);
      go = 1'b0;
      @(negedge clk);
      check_val("wd_exit_timeout", 32'(timeout), 0);
      check_val("wd_exit_busy", 32'(busy), 0);
`else
      repeat (20) @(negedge clk);
      check_val("nowd_timeout", 32'(timeout), 0);
      check_val("nowd_busy", 32'(busy), 1);
      check_val("nowd_cycles", 32'(cycle_count), 16);
      $display("txn no_watchdog: busy=%0d cycle_count=%0d", busy, cycle_count);
      reset_n = 1'b0;
      go      = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
`endif
      back_to_idle();

      // 15 runs, go dropped mid-sequence, run_idx ends all-ones
      done_at = 1; done_runs = 16;
      start_seq(4'd15, 16'd0);
      repeat (4) @(negedge clk);
      go = 1'b0;
      starts = 0;
      wait_end(300, starts);
      check_val("max_runs_done", 32'(done), 1);
      check_val("max_runs_run_idx", 32'(run_idx), 15);
      check_val("max_runs_cycles", 32'(cycle_count), 1);
      $display("txn max_runs: run_idx=%0d starts_after_drop=%0d", run_idx, starts);
      @(negedge clk);
      check_val("max_runs_idle", 32'(done), 0);

      // three runs finishing on the first RUN cycle
      done_at = 0; done_runs = 16;
      start_seq(4'd3, 16'd0);
      starts = 0;
      wait_end(100, starts);
      check_val("quick_run_idx", 32'(run_idx), 3);
      check_val("quick_cycles", 32'(cycle_count), 0);
      check_val("quick_starts", 32'(starts), 3);
      $display("txn quick: run_idx=%0d starts=%0d", run_idx, starts);
      back_to_idle();

      // async reset mid-run in the second run at count 7
      done_at = 3; done_runs = 1;
      start_seq(4'd2, 16'd0);
      lat = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!core_reset && (run_idx == 4'd1) && (cycle_count == 16'd7)) begin lat = 1; break; end
      end
      check_val("mid_reset_reached", 32'(lat), 1);
      reset_n = 1'b0;
      go      = 1'b0;
      #1;
      check_val("mid_reset_core_reset", 32'(core_reset), 1);
      check_val("mid_reset_cycles", 32'(cycle_count), 0);
      check_val("mid_reset_run_idx", 32'(run_idx), 0);
      check_val("mid_reset_busy", 32'(busy), 0);
      check_val("mid_reset_core_start", 32'(core_start), 0);
      @(negedge clk);
      reset_n = 1'b1;
      starts = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (core_start) starts++;
      end
      check_val("post_reset_idle_busy", 32'(busy), 0);
      check_val("post_reset_starts", 32'(starts), 0);
      $display("txn mid_reset: core_reset=%0d run_idx=%0d cycle_count=%0d", core_reset, run_idx, cycle_count);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter RUN_WIDTH, default 4, width of the run count and run index.
REQ-002 Parameter CNT_WIDTH, default 16, width of the cycle counter and the watchdog limit.
REQ-003 Parameter RESET_CYCLES, default 2, number of cycles core_reset is held per run (legal range 1..15).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 go  input  1  host run request, level-sensitive.
REQ-007 num_runs  input  RUN_WIDTH  number of back-to-back core runs, sampled when leaving IDLE.
REQ-008 timeout_cycles  input  CNT_WIDTH  per-run watchdog limit, sampled when leaving IDLE; 0 disables the watchdog.
REQ-009 core_done  input  1  done flag from the CPU core.
REQ-010 core_reset  output  1  active-high reset driven to the CPU core.
REQ-011 core_start  output  1  start pulse driven to the CPU core.
REQ-012 busy  output  1  high in every state except IDLE, FIN and ERR.
REQ-013 done  output  1  high while in FIN.
REQ-014 timeout  output  1  high while in ERR.
REQ-015 run_idx  output  RUN_WIDTH  count of completed runs.
REQ-016 cycle_count  output  CNT_WIDTH  RUN-state cycle count of the current or last run.

Function
REQ-017 The FSM SHALL have states IDLE, RST, START, RUN, NEXT, FIN and ERR.
REQ-018 IDLE: core_reset=1, core_start=0; on go=1 SHALL latch num_runs and timeout_cycles and clear run_idx; next state is FIN if num_runs==0, else RST.
REQ-019 RST: core_reset=1 for exactly RESET_CYCLES cycles, then START.
REQ-020 START: core_reset=0, core_start=1 for exactly one cycle; cycle_count cleared to 0; next state RUN.
REQ-021 RUN: core_reset=0, core_start=0; each cycle with core_done=0, cycle_count SHALL increment, saturating at all-ones.
REQ-022 RUN exit on completion: core_done=1 SHALL move to NEXT, and cycle_count SHALL freeze.
REQ-023 RUN exit on watchdog: the latched limit is nonzero, core_done=0 and cycle_count equals the limit, so SHALL move to ERR.
REQ-024 Simultaneous core_done=1 and watchdog match SHALL be treated as completion; core_done wins.
REQ-025 NEXT: one cycle, core_reset=1, run_idx increments; next state is FIN if the new run_idx equals the latched num_runs, else RST.
REQ-026 FIN and ERR: core_reset=1; both SHALL hold until go=0, then return to IDLE. run_idx and cycle_count SHALL hold their values.
REQ-027 Deasserting go during RST, START, RUN or NEXT SHALL NOT abort the sequence.
REQ-028 Latency: go high in IDLE gives the first core_start rising RESET_CYCLES+1 cycles later.
REQ-029 run_idx SHALL NOT wrap; num_runs = 2^RUN_WIDTH-1 completes with run_idx all-ones.
REQ-030 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-031 On reset_n=0, the block SHALL asynchronously enter IDLE with core_reset=1, core_start=0, busy=0, done=0, timeout=0, run_idx=0 and cycle_count=0.
REQ-032 Reset mid-run SHALL abandon the sequence; after reset_n rises, the block SHALL wait in IDLE for go.

Configuration
REQ-033 Macro RUN_SEQ_WATCHDOG_EN: when defined, the watchdog is compiled in per REQ-023.
REQ-034 Without RUN_SEQ_WATCHDOG_EN: timeout_cycles is ignored, ERR is unreachable, timeout is tied 0, and the port list is unchanged.

Structure
REQ-035 The run_state_t enum and the RUN_SEQ_RESET_CYCLES default SHALL reside in package Definitions.
REQ-036 Sub-module run_cycle_counter SHALL implement the saturating CNT_WIDTH counter, with clear, enable and limit-compare output.

Verification
REQ-037 num_runs=2, timeout=0, core_done raised 10 cycles after each start -> exactly two one-cycle core_start pulses, then done=1, run_idx=2, cycle_count=10.
REQ-038 num_runs=0, go=1 -> FIN one cycle later, done=1, no core_start, core_reset stays 1.
REQ-039 num_runs=1, timeout=5, core_done never rises -> ERR when cycle_count=5, timeout=1, core_reset=1, busy=0.
REQ-040 timeout=5, core_done rises in the same cycle cycle_count reaches 5 -> NEXT then FIN, timeout=0.
REQ-041 reset_n pulsed low during RUN with cycle_count=7 -> immediately core_reset=1, cycle_count=0, run_idx=0, state IDLE.
REQ-042 go held high through FIN -> stays in FIN with no rerun; go=0 -> IDLE next cycle.
